// File: rtl/keypad_scanner_pkg.sv
// +----------------------------------------------------------------------+
// | keypad_pkg : shared sizes and key-set helpers for the keypad scanner |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package keypad_pkg;

    localparam int ROWS       = 4;
    localparam int COLS       = 4;
    localparam int KEYS       = ROWS * COLS;
    localparam int KEY_CODE_W = 4;

    function automatic logic is_one_hot(input logic [KEYS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < KEYS; i++) begin
            n += 32'(v[i]);
        end
        return (n == 1);
    endfunction

    // Index of the highest set bit; only meaningful when v is one-hot.
    function automatic logic [KEY_CODE_W-1:0] key_index(input logic [KEYS-1:0] v);
        logic [KEY_CODE_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < KEYS; i++) begin
            if (v[i]) begin
                idx = KEY_CODE_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scanner_if.sv
// +----------------------------------------------------------------------+
// | keypad_scanner_if : key event bundle from scanner to its consumer    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [KEY_CODE_W-1:0] key_code;
    logic                  key_valid;
    logic                  key_down;

    modport master (output key_code, output key_valid, output key_down);
    modport slave  (input  key_code, input  key_valid, input  key_down);

endinterface

`default_nettype wire

// File: rtl/keypad_scanner_debounce.sv
// +----------------------------------------------------------------------+
// | key_debounce : accepts a full-matrix snapshot once it repeats        |
// | DEBOUNCE_SCANS times in a row. Rev 1.0                               |
// +----------------------------------------------------------------------+
`default_nettype none

module key_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            snap_valid,
    input  logic [KEYS-1:0] snap,
    output logic            deb_valid,
    output logic [KEYS-1:0] deb
);

    localparam int            STAB_W   = $clog2(DEBOUNCE_SCANS) + 1;
    localparam [STAB_W-1:0]   STAB_MAX = STAB_W'(DEBOUNCE_SCANS - 1);

    logic [KEYS-1:0]   prev_q, prev_d;
    logic [KEYS-1:0]   deb_q, deb_d;
    logic [STAB_W-1:0] stable_q, stable_d;
    logic              deb_valid_q, deb_valid_d;

    always_comb begin
        prev_d      = prev_q;
        stable_d    = stable_q;
        deb_d       = deb_q;
        deb_valid_d = 1'b0;
        if (snap_valid) begin
            prev_d = snap;
            if (snap == prev_q) begin
                stable_d = (stable_q == STAB_MAX) ? stable_q : stable_q + STAB_W'(1);
            end else begin
                stable_d = '0;
            end
            if ((stable_d == STAB_MAX) && (snap != deb_q)) begin
                deb_d       = snap;
                deb_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q      <= '0;
            stable_q    <= '0;
            deb_q       <= '0;
            deb_valid_q <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            stable_q    <= stable_d;
            deb_q       <= deb_d;
            deb_valid_q <= deb_valid_d;
        end
    end

    assign deb       = deb_q;
    assign deb_valid = deb_valid_q;

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// +----------------------------------------------------------------------+
// | keypad_scanner : 4x4 row-scanned keypad with debounced single-key    |
// | press events. Rev 1.0                                                |
// +----------------------------------------------------------------------+
`default_nettype none

module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS     = 12000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [COLS-1:0]     col_n,
    output logic [ROWS-1:0]     row_n,
    keypad_scanner_if.master    key_if
);

    localparam int              TICK_W    = $clog2(SCAN_TICKS);
    localparam [TICK_W-1:0]     TICK_LAST = TICK_W'(SCAN_TICKS - 1);
    localparam int              ROW_W     = $clog2(ROWS);
    localparam [ROW_W-1:0]      ROW_LAST  = ROW_W'(ROWS - 1);

    logic [COLS-1:0]       col_s1_q, col_s1_d, col_s2_q, col_s2_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [ROW_W-1:0]      row_idx_q, row_idx_d;
    logic [ROWS-1:0]       row_n_q, row_n_d;
    logic [KEYS-1:0]       snap_q, snap_d;
    logic                  snap_valid;
    logic [KEYS-1:0]       deb;
    logic                  deb_valid;
    logic [KEYS-1:0]       deb_prev_q, deb_prev_d;
    logic [KEY_CODE_W-1:0] key_code_q, key_code_d;
    logic                  key_valid_q, key_valid_d;
    logic                  key_down_q, key_down_d;

    // Columns are sampled at the end of each row slot so the row lines have settled.
    always_comb begin
        col_s1_d   = col_n;
        col_s2_d   = col_s1_q;
        tick_d     = tick_q + TICK_W'(1);
        row_idx_d  = row_idx_q;
        row_n_d    = row_n_q;
        snap_d     = snap_q;
        snap_valid = 1'b0;
        if (tick_q == TICK_LAST) begin
            tick_d    = '0;
            row_idx_d = row_idx_q + ROW_W'(1);
            row_n_d   = {row_n_q[ROWS-2:0], row_n_q[ROWS-1]};
            snap_d[int'(row_idx_q)*COLS +: COLS] = ~col_s2_q;
            snap_valid = (row_idx_q == ROW_LAST);
        end
    end

    key_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk        (clk),
        .reset_n    (reset_n),
        .snap_valid (snap_valid),
        .snap       (snap_d),
        .deb_valid  (deb_valid),
        .deb        (deb)
    );

    // A press event needs the previous debounced state to be all-released.
    always_comb begin
        deb_prev_d  = deb_prev_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        if (deb_valid) begin
            deb_prev_d = deb;
            key_down_d = is_one_hot(deb);
            if (is_one_hot(deb) && (deb_prev_q == '0)) begin
                key_valid_d = 1'b1;
                key_code_d  = key_index(deb);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_s1_q    <= '1;
            col_s2_q    <= '1;
            tick_q      <= '0;
            row_idx_q   <= '0;
            row_n_q     <= {{(ROWS-1){1'b1}}, 1'b0};
            snap_q      <= '0;
            deb_prev_q  <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            col_s1_q    <= col_s1_d;
            col_s2_q    <= col_s2_d;
            tick_q      <= tick_d;
            row_idx_q   <= row_idx_d;
            row_n_q     <= row_n_d;
            snap_q      <= snap_d;
            deb_prev_q  <= deb_prev_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    assign row_n            = row_n_q;
    assign key_if.key_code  = key_code_q;
    assign key_if.key_valid = key_valid_q;
    assign key_if.key_down  = key_down_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// +----------------------------------------------------------------------+
// | tb_keypad_scanner : keypad matrix model plus scan-level reference    |
// | model for keypad_scanner. Rev 1.0                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int SCAN_TICKS     = 4;
    localparam int DEBOUNCE_SCANS = 2;
    localparam int SCAN           = SCAN_TICKS * ROWS;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [15:0] keys    = '0;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_TICKS     (SCAN_TICKS),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .col_n   (col_n),
        .row_n   (row_n),
        .key_if  (kif)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key shorts its column to its row.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (row_n[r] == 1'b0 && keys[r*4+c]) col_n[c] = 1'b0;
            end
        end
    end

    int          checks = 0;
    int          errors = 0;
    int          nstrobe;
    int          e;
    logic [15:0] hist[$];
    logic [15:0] snaps[$];
    logic [15:0] srow, m_deb;
    logic        m_valid, m_down;
    logic [3:0]  m_code;
    logic        pend, pend_strobe, pend_down;
    logic [3:0]  pend_code;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] idx_of(input logic [15:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) if (v[i]) r = 4'(i);
        return r;
    endfunction

    task automatic model_reset();
        hist.delete();
        snaps.delete();
        snaps.push_back(16'h0);
        srow = '0; m_deb = '0; m_valid = 0; m_code = '0; m_down = 0;
        pend = 0; pend_strobe = 0; pend_down = 0; pend_code = '0;
        e = 0;
    endtask

    // Reference model of what edge number e does, at scan/row granularity.
    task automatic model_edge();
        logic [15:0] seen;
        int          r;
        logic        steady;
        m_valid = 1'b0;
        if (pend) begin
            m_valid = pend_strobe;
            if (pend_strobe) m_code = pend_code;
            m_down = pend_down;
            pend   = 1'b0;
        end
        if (e % SCAN_TICKS == SCAN_TICKS - 1) begin
            r    = (e / SCAN_TICKS) % ROWS;
            seen = hist[e-2];
            srow[r*4 +: 4] = seen[r*4 +: 4];
        end
        if (e % SCAN == SCAN - 1) begin
            snaps.push_back(srow);
            steady = (snaps.size() >= DEBOUNCE_SCANS);
            for (int i = 1; i < DEBOUNCE_SCANS; i++) begin
                if (steady && snaps[snaps.size()-1-i] != srow) steady = 1'b0;
            end
            if (steady && srow != m_deb) begin
                pend        = 1'b1;
                pend_strobe = ($countones(srow) == 1) && (m_deb == 16'h0);
                pend_code   = idx_of(srow);
                pend_down   = ($countones(srow) == 1);
                m_deb       = srow;
            end
        end
    endtask

    task automatic cycle();
        logic [3:0] exp_row;
        hist.push_back(keys);
        @(posedge clk);
        model_edge();
        e++;
        @(negedge clk);
        exp_row = ~(4'b0001 << ((e / SCAN_TICKS) % ROWS));
        chk("row_n", 16'(row_n), 16'(exp_row));
        chk("key_valid", 16'(kif.key_valid), 16'(m_valid));
        chk("key_code", 16'(kif.key_code), 16'(m_code));
        chk("key_down", 16'(kif.key_down), 16'(m_down));
        if (kif.key_valid === 1'b1) nstrobe++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic align(input int ph);
        for (int i = 0; i < SCAN && (e % SCAN) != ph; i++) cycle();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_row_n"}, 16'(row_n), 16'(4'b1110));
        chk({tag, "_valid"}, 16'(kif.key_valid), 16'h0);
        chk({tag, "_down"},  16'(kif.key_down), 16'h0);
        chk({tag, "_code"},  16'(kif.key_code), 16'h0);
    endtask

    initial begin
        model_reset();
        nstrobe = 0;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;
        model_reset();
        run(2 * SCAN);

        // Single press of key 6 from the start of a scan, then release.
        align(0);
        keys = 16'h1 << 6; nstrobe = 0;
        run(3 * SCAN);
        chk("press6_strobes", 16'(nstrobe), 16'd1);
        chk("press6_code", 16'(kif.key_code), 16'd6);
        chk("press6_down", 16'(kif.key_down), 16'd1);
        keys = '0; nstrobe = 0;
        run(3 * SCAN);
        chk("rel6_strobes", 16'(nstrobe), 16'd0);
        chk("rel6_down", 16'(kif.key_down), 16'd0);
        chk("rel6_code", 16'(kif.key_code), 16'd6);

        // Key 15 bouncing with a 7-cycle half period, then held.
        align(3);
        nstrobe = 0;
        for (int i = 0; i < 3 * SCAN; i++) begin
            keys = (((i / 7) % 2) == 0) ? (16'h1 << 15) : 16'h0;
            cycle();
        end
        chk("bounce_strobes", 16'(nstrobe), 16'd0);
        keys = 16'h1 << 15;
        run(3 * SCAN);
        chk("bounce_held_strobes", 16'(nstrobe), 16'd1);
        chk("bounce_code", 16'(kif.key_code), 16'd15);
        keys = '0;
        run(3 * SCAN);

        // Five-cycle glitch on key 0 at a random phase.
        align(int'($urandom_range(0, SCAN - 1)));
        nstrobe = 0;
        keys = 16'h1;
        run(5);
        keys = '0;
        run(3 * SCAN);
        chk("glitch_strobes", 16'(nstrobe), 16'd0);
        chk("glitch_down", 16'(kif.key_down), 16'd0);

        // Multi-key: 1+4, back to 1, all released, then 4 alone.
        align(0);
        keys = (16'h1 << 1) | (16'h1 << 4); nstrobe = 0;
        run(3 * SCAN);
        chk("multi_strobes", 16'(nstrobe), 16'd0);
        chk("multi_down", 16'(kif.key_down), 16'd0);
        keys = 16'h1 << 1;
        run(3 * SCAN);
        chk("multi_to_one_strobes", 16'(nstrobe), 16'd0);
        keys = '0;
        run(3 * SCAN);
        keys = 16'h1 << 4; nstrobe = 0;
        run(3 * SCAN);
        chk("press4_strobes", 16'(nstrobe), 16'd1);
        chk("press4_code", 16'(kif.key_code), 16'd4);
        keys = '0;
        run(3 * SCAN);

        // Random key sets and hold times, judged entirely by the model.
        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 3))
                0:       keys = '0;
                1:       keys = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
                default: keys = 16'h1 << $urandom_range(0, 15);
            endcase
            run(int'($urandom_range(3, 60)));
        end
        keys = '0;
        run(3 * SCAN);

        // Reset in the middle of row 2 with key 9 already accepted.
        align(0);
        keys = 16'h1 << 9; nstrobe = 0;
        run(3 * SCAN);
        chk("press9_strobes", 16'(nstrobe), 16'd1);
        chk("press9_code", 16'(kif.key_code), 16'd9);
        align(2 * SCAN_TICKS + 1);
        reset_n = 1'b0;
        #1;
        check_reset_values("midreset");
        repeat (2) @(negedge clk);
        check_reset_values("midreset_hold");
        reset_n = 1'b1;
        model_reset();
        nstrobe = 0;
        run(4 * SCAN);
        chk("after_reset_strobes", 16'(nstrobe), 16'd1);
        chk("after_reset_code", 16'(kif.key_code), 16'd9);
        chk("after_reset_down", 16'(kif.key_down), 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Time-multiplexed 4x4 matrix keypad reader for the board GPIO header; the input-side counterpart of the time-multiplexed hex display driver.
- Drives one row low at a time and samples the active-low columns.
- Debounces whole-matrix snapshots and reports single-key press events as a key code plus a one-cycle strobe.
- Its output feeds the display mux / application logic in board-level test tops.

Parameters:
SCAN_TICKS, 12000, clk cycles each row is driven (1 ms at 12 MHz); minimum 4
DEBOUNCE_SCANS, 4, consecutive identical full-matrix snapshots required before acceptance; minimum 1
(ROWS=4, COLS=4 fixed; taken from the package)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
col_n  input  4  column lines, active-low, externally pulled up, asynchronous to clk
row_n  output  4  row drive, active-low, exactly one bit low at all times
key_code  output  4  index of last accepted key = row*4 + col; held until next accept
key_valid  output  1  one-cycle strobe when a new key press is accepted
key_down  output  1  high while the debounced state holds exactly one pressed key

Behaviour:
- Reset (async assert, sync release) values: row_n=4'b1110, tick=0, row index=0, all snapshots/debounced state=0, key_code=0, key_valid=0, key_down=0, stable count=0.
- col_n passes through a 2-flop synchronizer before any use; 2-cycle input latency.
- Tick counter: counts 0..SCAN_TICKS-1 and wraps. On wrap, row index advances 0->1->2->3->0 and row_n rotates its low bit (row r low means row_n[r]=0).
- Sampling: on tick==SCAN_TICKS-1, the synchronized ~col_n is written into snapshot bits [r*4+3 : r*4]. Late sampling lets row lines settle.
- Full scan = 4*SCAN_TICKS cycles. A scan completes at the sample point of row 3; the assembled 16-bit snapshot is committed that cycle.
- Debounce on each committed snapshot S:
  - If S == previous snapshot: stable count increments, saturating at DEBOUNCE_SCANS-1. Otherwise stable count resets to 0.
  - If stable count (after update) == DEBOUNCE_SCANS-1 and S != debounced state: debounced state <= S.
  - DEBOUNCE_SCANS=1 means every snapshot is accepted immediately.
- Event decode: registered, evaluated the cycle after a debounced update.
  - New debounced has exactly one bit set and old debounced had zero bits set: key_valid=1 for one cycle, key_code=bit index.
  - Any other transition (multi-key, roll-over 1->1 different key, release): no strobe, key_code unchanged.
- key_down: registered, 1 iff debounced state has exactly one bit set; updates in the same cycle as the key_valid decision.
- Multiple simultaneous keys (ghosting possible): never produce a strobe. Releasing back to a single key from a multi-key state does not strobe. A strobe requires passing through the all-released state.
- Glitch shorter than one full scan: can change at most one snapshot, so with DEBOUNCE_SCANS>=2 it is rejected.
- Reset mid-scan: everything returns to reset values immediately; no strobe is emitted on release of reset, even if a key is held (the held key strobes only after debounce from the zero state, which is correct and required).
- No width overflow: tick counter width = clog2(SCAN_TICKS); stable counter width = clog2(DEBOUNCE_SCANS)+1.

Decomposition:
- Package keypad_pkg: ROWS=4, COLS=4, KEYS=16, KEY_CODE_W=4, and the popcount-is-one function used for decode.
- One natural sub-module: key_debounce. It holds the snapshot compare, the stable counter and the debounced register, with ports clk, reset_n, snap_valid, snap[15:0], deb_valid, deb[15:0].
- Row/tick scanning and event decode stay in keypad_scanner.

Test Plan:
(Bench parameters SCAN_TICKS=4, DEBOUNCE_SCANS=2; one scan = 16 cycles.)
- Reset: reset_n=0 -> row_n=1110, key_valid=0, key_down=0, key_code=0. Release -> row_n steps 1110,1101,1011,0111 every 4 cycles, then wraps.
- Single press, key 6 (model pulls col_n[2] low while row_n[1]=0, held from scan start):
  - Exactly one key_valid pulse with key_code=6, key_down=1, within 2 scans + 3 cycles after the first scan that saw the press.
  - Release -> key_down=0 after 2 clean scans; no strobe; key_code stays 6.
- Bounce: key 15 toggles every 7 cycles for 3 scans, then held -> no strobe during bouncing; single strobe code 15 only after 2 stable scans.
- Glitch: key 0 asserted for 5 cycles only -> no key_valid, key_down stays 0.
- Multi-key:
  - Keys 1 and 4 pressed together -> no strobe, key_down=0.
  - Release key 4 (key 1 still held) -> still no strobe.
  - Release all, then press key 4 -> strobe with code 4.
- Reset mid-operation: key 9 held and accepted; assert reset_n=0 mid-row-2 -> outputs return to reset values at once; after release with key 9 still held -> one new strobe code 9 after debounce.
